mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified instruction/data memory between the instruction-fetch stage and the load/store path driven by the control unit's `read_mem`/`write_mem` decode. The block arbitrates requests and keeps one transaction outstanding at a time. It returns read data to the correct requester after a fixed memory latency and raises a fetch stall toward the PC stage when fetch is not granted.

## Interface
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, data width. Fixed at 32; byte enables are 4 bits.
- `MEM_LAT`, 1, memory read latency in cycles. Legal range is 1..4.
- `MAX_D_STREAK`, 4, maximum consecutive data grants while fetch is waiting. Legal range is 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request. It is a level signal, held until granted.
- `if_addr` in ADDR_W: fetch address. Must be stable while `if_req` is high.
- `if_gnt` out 1: fetch granted this cycle.
- `if_rvalid` out 1: fetch data valid (1-cycle pulse).
- `if_rdata` out DATA_W: fetch data.
- `d_req` in 1: data request. It is the OR of `read_mem` and `write_mem`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_be` in 4: byte enables (sb/sh/sw).
- `d_gnt` out 1: data granted this cycle.
- `d_rvalid` out 1: load data valid or store acknowledge (1-cycle pulse).
- `d_rdata` out DATA_W: load data. It is 0 on a store acknowledge.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_be` out 4: memory byte enables.
- `mem_rdata` in DATA_W: memory read data. Valid `MEM_LAT` cycles after `mem_en`.
- `stall_o` out 1: equals `if_req & ~if_gnt`.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: one transaction outstanding. `owner` ∈ {IF, D}, latency counter `lat_cnt`.
- Issue conditions:
  - A new transaction may issue in IDLE.
  - It may also issue in the BUSY cycle where `lat_cnt == MEM_LAT`, which is the completion cycle.
  - Result: back-to-back issue is possible and throughput is one access per `MEM_LAT` cycles.
- Issue cycle behaviour:
  - The arbiter picks a winner and asserts the winner's `gnt` combinationally.
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` are driven combinationally from the winner in the same cycle.
  - `mem_we = 0` and `mem_be = 4'hF` for fetch.
  - The FSM enters BUSY with `lat_cnt = 1` and `owner = winner`.
- Priority:
  - Data beats fetch by default, because the load/store belongs to the older instruction.
  - Exception: if `d_streak == MAX_D_STREAK` and `if_req` is high, fetch wins.
- `d_streak` counter:
  - Increments on a data grant while `if_req` is high.
  - Clears on a fetch grant.
  - Clears on any cycle with `if_req` low.
  - Saturates at `MAX_D_STREAK`.
- BUSY:
  - `lat_cnt` increments each cycle.
  - When `lat_cnt == MAX_LAT`... specifically when `lat_cnt == MEM_LAT`, the owner's `rvalid` pulses. Its `rdata` is `mem_rdata` for reads and 0 for stores.
  - The FSM then either issues again (stays BUSY) or returns to IDLE.
- A requester may drop `req` before it is granted (withdraw). There is no penalty and no grant is given.
- No request is accepted while BUSY except in the completion cycle.
- Reset, asynchronous:
  - FSM goes to IDLE, `lat_cnt = 0`, `d_streak = 0`.
  - All outputs go to 0: `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `if_rdata`, `d_rdata`. `stall_o` becomes 0 once requests deassert.
  - A transaction in flight when reset asserts is discarded and never produces `rvalid`.

## Timing
- Issue at cycle t gives `rvalid` at t+`MEM_LAT`. The earliest next issue is t+`MEM_LAT`.
- With `MEM_LAT = 1`, continuous requests are granted every cycle.
- `gnt` and `mem_en` are combinational from `req` in an issue-eligible cycle.
- `rvalid` and `rdata` are combinational from FSM state and `mem_rdata`. There are no extra output registers.
- `stall_o` is combinational. It is high during every cycle fetch waits, including all BUSY non-completion cycles.
- When both requests are pending, `MEM_LAT = 1` and `MAX_D_STREAK = N`, the grant pattern is N data grants, then 1 fetch grant, repeating.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum {IDLE, BUSY}
  - owner enum {OWN_IF, OWN_D}
  - `MEM_LAT_MAX = 4`
  - `BE_WORD = 4'hF`
- Optional sub-module `mem_arb_sel`: combinational winner select from `if_req`, `d_req` and `d_streak`. Everything else stays in the top module.
- Expected size is about 150–220 lines of RTL.

## Test plan
- Fetch only, `MEM_LAT=1`: `if_req` held high with addresses 0x0, 0x4, 0x8. Required: `if_gnt` every cycle, `if_rvalid` one cycle after each grant with the matching `mem_rdata`, `stall_o = 0`.
- Simultaneous load and fetch, `MEM_LAT=2`: `d_req` at 0x100 and `if_req` at 0x40. Required: `d_gnt` at t, `d_rvalid` at t+2, `if_gnt` at t+2, `if_rvalid` at t+4, `stall_o` high for t..t+1.
- Starvation bound, `MAX_D_STREAK=4`: `d_req` and `if_req` held continuously. Required: grants D,D,D,D,IF,D,D,D,D,IF and so on.
- Store ack: `d_we=1`, `d_be=4'b0011`, `d_wdata=0xDEADBEEF` at 0x200. Required: `mem_we=1`, `mem_be=0011`, `d_rvalid` after `MEM_LAT` cycles with `d_rdata=0`.
- Withdraw: `if_req` asserted while BUSY, then dropped before the completion cycle. Required: no `if_gnt`, no `if_rvalid`, FSM returns to IDLE.
- Reset mid-operation: `rst` asserted at t+1 after a load issued at t with `MEM_LAT=3`. Required: immediate return to IDLE, all outputs 0, no `d_rvalid` ever for that load.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Holds the FSM state enum, the transaction-owner enum and the fixed constants.
// No logic lives here; the package is imported by the arbiter and its selector.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Largest supported memory read latency; sizes the latency counter.
  localparam int MEM_LAT_MAX = 4;

  // Fetches always read a full word.
  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner select between fetch and data requests for the shared memory port.
// Latency: purely combinational, no state.
// Backpressure: none here; the caller only honours the winner in an issue-eligible cycle.
module mem_arb_sel #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic       if_req,
  input  logic       d_req,
  input  logic [3:0] d_streak,
  output logic       win_if,
  output logic       win_d
);

  logic fetch_first;

  // Data normally wins (older instruction); fetch wins alone, or once data
  // has taken MAX_D_STREAK grants in a row while fetch was waiting.
  always_comb begin
    fetch_first = if_req & (~d_req | (d_streak == 4'(MAX_D_STREAK)));
    win_if      = fetch_first;
    win_d       = d_req & ~fetch_first;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one single-port memory, one access in flight.
// Latency: grant and memory strobe same cycle as request; rvalid MEM_LAT cycles after grant.
// Backpressure: requests are held (level) until granted; fetch waiting raises stall_o.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_o
);

  localparam int LAT_W = $clog2(MEM_LAT_MAX + 1);

  state_t           state;
  owner_t           owner;
  logic             own_we;    // outstanding data access is a store
  logic [LAT_W-1:0] lat_cnt;
  logic [3:0]       d_streak;

  logic complete;
  logic issue_ok;
  logic win_if;
  logic win_d;

  // Completion cycle doubles as an issue slot, giving back-to-back access.
  // Reset masks the grant so nothing is strobed while rst is held.
  assign complete = (state == BUSY) && (lat_cnt == LAT_W'(MEM_LAT));
  assign issue_ok = ~rst & ((state == IDLE) | complete);

  mem_arb_sel #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_sel (
    .if_req  (if_req),
    .d_req   (d_req),
    .d_streak(d_streak),
    .win_if  (win_if),
    .win_d   (win_d)
  );

  assign if_gnt  = issue_ok & win_if;
  assign d_gnt   = issue_ok & win_d;
  assign stall_o = if_req & ~if_gnt;

  // Memory command is driven straight from whichever requester was granted.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'h0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      mem_be   = BE_WORD;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end
  end

  // Response steering in the completion cycle; stores return zero data.
  always_comb begin
    if_rvalid = complete & (owner == OWN_IF);
    d_rvalid  = complete & (owner == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid & ~own_we) ? mem_rdata : '0;
  end

  // Transaction FSM: track owner and latency of the single outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_IF;
      own_we  <= 1'b0;
      lat_cnt <= '0;
    end else if (if_gnt | d_gnt) begin
      state   <= BUSY;
      owner   <= d_gnt ? OWN_D : OWN_IF;
      own_we  <= d_gnt & d_we;
      lat_cnt <= LAT_W'(1);
    end else if (state == BUSY) begin
      if (complete) begin
        state   <= IDLE;
        own_we  <= 1'b0;
        lat_cnt <= '0;
      end else begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end
    end
  end

  // Count data grants taken while fetch waits; bounds fetch starvation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_streak <= 4'd0;
    end else if (~if_req | if_gnt) begin
      d_streak <= 4'd0;
    end else if (d_gnt && (d_streak != 4'(MAX_D_STREAK))) begin
      d_streak <= d_streak + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1/2/3) share one stimulus stream.
// A timestamp-based transaction model predicts every output of every instance each cycle.
// Directed scenarios add literal expectations on top of the model.
module tb_mem_port_arbiter;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] mem_rdata;

  logic [ND-1:0] if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a, mem_en_a, mem_we_a, stall_a;
  logic [31:0]   if_rdata_a [ND];
  logic [31:0]   d_rdata_a  [ND];
  logic [31:0]   mem_addr_a [ND];
  logic [31:0]   mem_wdata_a[ND];
  logic [3:0]    mem_be_a   [ND];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: one pending access per instance, identified by its issue cycle.
  int cyc = 0;
  bit pend   [ND];
  int iss_cyc[ND];
  bit own_d  [ND];
  bit own_st [ND];
  int streak [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .MEM_LAT     (g + 1),
      .MAX_D_STREAK(g == 2 ? 1 : 4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt_a[g]),
      .if_rvalid(if_rvalid_a[g]),
      .if_rdata (if_rdata_a[g]),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_be     (d_be),
      .d_gnt    (d_gnt_a[g]),
      .d_rvalid (d_rvalid_a[g]),
      .d_rdata  (d_rdata_a[g]),
      .mem_en   (mem_en_a[g]),
      .mem_we   (mem_we_a[g]),
      .mem_addr (mem_addr_a[g]),
      .mem_wdata(mem_wdata_a[g]),
      .mem_be   (mem_be_a[g]),
      .mem_rdata(mem_rdata),
      .stall_o  (stall_a[g])
    );
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d got %h expected %h (cycle %0d)", nm, k, act, exp, cyc);
    end
  endtask

  // Predict and compare all outputs of all instances for the current cycle,
  // then advance the model as the coming clock edge will.
  task automatic model_step();
    for (int k = 0; k < ND; k++) begin
      int lat = k + 1;
      int mx  = (k == 2) ? 1 : 4;
      bit comp, elig, fw, ig, dg;
      comp = !rst && pend[k] && (cyc == iss_cyc[k] + lat);
      elig = !rst && (!pend[k] || comp);
      fw   = if_req && (!d_req || streak[k] == mx);
      ig   = elig && fw;
      dg   = elig && d_req && !fw;
      chk("if_gnt",    k, if_gnt_a[k],    ig);
      chk("d_gnt",     k, d_gnt_a[k],     dg);
      chk("stall",     k, stall_a[k],     if_req && !ig);
      chk("mem_en",    k, mem_en_a[k],    ig || dg);
      chk("mem_we",    k, mem_we_a[k],    dg && d_we);
      chk("mem_addr",  k, mem_addr_a[k],  ig ? if_addr : (dg ? d_addr : 32'h0));
      chk("mem_wdata", k, mem_wdata_a[k], dg ? d_wdata : 32'h0);
      chk("mem_be",    k, 32'(mem_be_a[k]), ig ? 32'hF : (dg ? 32'(d_be) : 32'h0));
      chk("if_rvalid", k, if_rvalid_a[k], comp && !own_d[k]);
      chk("if_rdata",  k, if_rdata_a[k],  (comp && !own_d[k]) ? mem_rdata : 32'h0);
      chk("d_rvalid",  k, d_rvalid_a[k],  comp && own_d[k]);
      chk("d_rdata",   k, d_rdata_a[k],   (comp && own_d[k] && !own_st[k]) ? mem_rdata : 32'h0);
      if (rst) begin
        pend[k]   = 1'b0;
        streak[k] = 0;
      end else begin
        if (ig || dg) begin
          pend[k]    = 1'b1;
          iss_cyc[k] = cyc;
          own_d[k]   = dg;
          own_st[k]  = dg && d_we;
        end else if (comp) begin
          pend[k] = 1'b0;
        end
        if (!if_req || ig) streak[k] = 0;
        else if (dg && streak[k] < mx) streak[k]++;
      end
    end
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    mem_rdata = $urandom;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  task automatic quiet(input int n);
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
    for (int k = 0; k < ND; k++) begin
      pend[k] = 1'b0; iss_cyc[k] = 0; own_d[k] = 1'b0; own_st[k] = 1'b0; streak[k] = 0;
    end

    // Reset state
    sample();
    chk("rst_mem_en", 0, 32'(mem_en_a), 32'h0);
    chk("rst_rvalid", 0, 32'(if_rvalid_a | d_rvalid_a), 32'h0);
    adv();
    rst = 1'b0;
    quiet(2);

    // Fetch only on MEM_LAT=1: grant every cycle, data one cycle later
    begin
      logic [31:0] prev_rd;
      prev_rd = '0;
      if_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if_addr = 32'(4 * i);
        sample();
        chk("lit_fetch_gnt",   0, if_gnt_a[0],   1'b1);
        chk("lit_fetch_addr",  0, mem_addr_a[0], 32'(4 * i));
        chk("lit_fetch_stall", 0, stall_a[0],    1'b0);
        if (i > 0) chk("lit_fetch_rdata", 0, if_rdata_a[0], mem_rdata);
        prev_rd = mem_rdata;
        adv();
      end
      if_req = 1'b0;
      sample();
      chk("lit_fetch_last_rv", 0, if_rvalid_a[0], 1'b1);
      adv();
    end
    quiet(5);

    // Load and fetch together on MEM_LAT=2
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h40;
    sample();
    chk("lit_ld_dgnt_t",  1, d_gnt_a[1],  1'b1);
    chk("lit_ld_stall_t", 1, stall_a[1],  1'b1);
    adv(); d_req = 1'b0;
    sample();
    chk("lit_ld_stall_t1", 1, stall_a[1], 1'b1);
    adv();
    sample();
    chk("lit_ld_drv_t2",  1, d_rvalid_a[1], 1'b1);
    chk("lit_ld_igt_t2",  1, if_gnt_a[1],   1'b1);
    chk("lit_ld_addr_t2", 1, mem_addr_a[1], 32'h40);
    adv(); if_req = 1'b0;
    tick();
    mem_rdata = 32'hCAFE0040;
    sample();
    chk("lit_ld_irv_t4", 1, if_rvalid_a[1], 1'b1);
    chk("lit_ld_ird_t4", 1, if_rdata_a[1],  32'hCAFE0040);
    adv();
    quiet(5);

    // Starvation bound on MEM_LAT=1, MAX_D_STREAK=4: D,D,D,D,IF repeating
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; if_req = 1'b1; if_addr = 32'h80;
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("lit_starve_if", 0, if_gnt_a[0], (i % 5) == 4);
      chk("lit_starve_d",  0, d_gnt_a[0],  (i % 5) != 4);
      adv();
    end
    quiet(5);

    // Store acknowledge on MEM_LAT=1
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEADBEEF; d_addr = 32'h200;
    sample();
    chk("lit_st_we",    0, mem_we_a[0],    1'b1);
    chk("lit_st_be",    0, 32'(mem_be_a[0]), 32'h3);
    chk("lit_st_wdata", 0, mem_wdata_a[0], 32'hDEADBEEF);
    adv(); d_req = 1'b0; d_we = 1'b0; mem_rdata = 32'h12345678;
    sample();
    chk("lit_st_rvalid", 0, d_rvalid_a[0], 1'b1);
    chk("lit_st_rdata",  0, d_rdata_a[0],  32'h0);
    adv();
    quiet(5);

    // Withdraw on MEM_LAT=3: fetch raised while busy and dropped before completion
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    sample(); chk("lit_wd_dgnt", 2, d_gnt_a[2], 1'b1); adv();
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h600;
    sample(); chk("lit_wd_gnt1", 2, if_gnt_a[2], 1'b0); adv();
    sample(); chk("lit_wd_gnt2", 2, if_gnt_a[2], 1'b0); adv();
    if_req = 1'b0;
    sample();
    chk("lit_wd_gnt3", 2, if_gnt_a[2],   1'b0);
    chk("lit_wd_drv",  2, d_rvalid_a[2], 1'b1);
    adv();
    sample();
    chk("lit_wd_idle", 2, mem_en_a[2],    1'b0);
    chk("lit_wd_irv",  2, if_rvalid_a[2], 1'b0);
    adv();
    quiet(5);

    // Reset one cycle after a load issues on MEM_LAT=3
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    sample(); chk("lit_rst_dgnt", 2, d_gnt_a[2], 1'b1); adv();
    d_req = 1'b0; rst = 1'b1;
    sample();
    chk("lit_rst_en",  2, mem_en_a[2],   1'b0);
    chk("lit_rst_drv", 2, d_rvalid_a[2], 1'b0);
    adv();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("lit_rst_no_drv", 2, d_rvalid_a[2], 1'b0);
      adv();
    end

    // Randomised traffic, including occasional reset pulses
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      if_req  = ($urandom_range(0, 3) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1) == 1;
      if_addr = $urandom & 32'hFFFF_FFFC;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_be    = 4'($urandom);
      tick();
    end
    rst = 1'b0;
    quiet(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
